memory_responder: RTL
=====================

// Module: memory_responder
// PURPOSE
// - Memory-side responder to the CPU control unit's MAR/write/bus interface.
// - Decodes the 8-bit MAR address and serves four regions: program ROM, data RAM,
//   memory-mapped output ports and synchronised input ports.
// - Returns read data combinationally on Bus2 (memory) and commits writes from Bus1.
// - Contains a byte-stream program loader that fills ROM while the CPU is held.
// PARAMETERS
// - RAM_BASE     8'h80  first RAM address; ROM spans 8'h00 .. RAM_BASE-1
// - OUT_BASE     8'hE0  first output-port address; RAM spans RAM_BASE .. OUT_BASE-1
// - IN_BASE      8'hF0  first input-port address; out ports OUT_BASE..IN_BASE-1, in ports IN_BASE..8'hFF
// - SYNC_STAGES  2      flip-flop stages on port_in (legal values: 2 or 3)
// PORTS
// - Clk       in   1    clock; all state changes on posedge
// - Reset     in   1    asynchronous, active-high reset
// - address   in   8    MAR output from CPU
// - data_in   in   8    write data (CPU Bus1)
// - write     in   1    CPU write strobe; sampled at posedge
// - data_out  out  8    read data to CPU (Bus2 memory source); combinational
// - port_in   in   128  16 input bytes; byte k = port_in[8k+7:8k]
// - port_out  out  128  16 registered output bytes, same packing as port_in
// - wr_fault  out  1    sticky flag: CPU wrote to ROM or to an input port
// - ld_start  in   1    one-cycle pulse; starts a ROM load
// - ld_valid  in   1    loader byte valid
// - ld_data   in   8    loader byte
// - ld_last   in   1    qualifies the final byte of a load
// - ld_ready  out  1    loader may transfer (1 only in LOAD)
// - ld_done   out  1    one-cycle pulse when a load finishes
// - ld_ovf    out  1    sticky flag: ROM filled before ld_last
// - cpu_hold  out  1    CPU must stall (asserted in LOAD and DONE)
// BEHAVIOUR
// - Reset values:
//   - port_out, wr_fault, ld_ready, ld_done, ld_ovf, cpu_hold = 0
//   - sync flops = 0; FSM = IDLE; load pointer = 0
//   - ROM/RAM contents are NOT reset.
// - Reads (combinational, zero latency):
//   - ROM/RAM address: data_out = stored byte.
//   - OUT range: data_out = current port_out byte.
//   - IN range: data_out = synchronised port_in byte (final sync stage).
//   - While cpu_hold=1: data_out = 8'h00.
// - Writes (cpu_hold=0, write=1, at posedge):
//   - RAM: byte updated; visible on data_out the same cycle after the edge.
//   - OUT: port_out byte updated at that edge.
//   - ROM or IN: no storage change; wr_fault <= 1.
//   - wr_fault clears only on Reset.
// - Input sync: a port_in change is readable SYNC_STAGES edges later.
// - Loader FSM:
//   - IDLE: ld_start=1 -> LOAD; pointer <= 0; ld_ovf <= 0.
//   - LOAD: ld_ready=1 and cpu_hold=1.
//     - On ld_valid & ld_ready: ROM[pointer] <= ld_data; pointer++.
//     - If ld_last on that transfer -> DONE.
//     - If pointer == RAM_BASE-1 and ld_last=0: byte written, ld_ovf <= 1 -> DONE.
//     - Cycles with ld_valid=0 cause no change.
//   - DONE (1 cycle): ld_done=1, cpu_hold=1, ld_ready=0 -> IDLE.
//   - ld_start is ignored outside IDLE.
// - Priority: during LOAD/DONE, CPU write strobes are ignored and do not set wr_fault.
// - Reset mid-load: FSM -> IDLE, hold released; ROM bytes already written are kept.
// - Address boundaries are exact:
//   - RAM_BASE-1 is ROM; OUT_BASE-1 is RAM; IN_BASE-1 is OUT; 8'hFF is IN port 15.
// TESTING
// - Load 3 bytes A0,A1,A2 (ld_last on A2) -> ROM[0..2] = A0..A2; ld_done pulses
//   1 cycle; cpu_hold drops the cycle after DONE; ld_ovf=0.
// - Stream 129 bytes with no ld_last -> ROM[0..7F] filled; ld_ovf=1 after byte 128;
//   byte 129 is not accepted (ld_ready=0).
// - write=1, address=8'h80, data_in=8'h5A -> read of 8'h80 returns 5A;
//   address=8'hDF boundary behaves the same.
// - write 8'h3C to 8'hE5 -> port_out[47:40] = 3C the same edge;
//   write to 8'h10 and to 8'hF0 -> ROM/IN unchanged, wr_fault = 1.
// - port_in[7:0] changes to 8'h77 -> read of 8'hF0 returns 77 exactly SYNC_STAGES edges later.
// - Assert Reset after 2 loader bytes -> FSM IDLE, cpu_hold = 0, ROM[0..1] retained,
//   port_out = 0.

Source files
------------

// File: rtl/memory_responder_if.sv
// CPU bus, I/O port and loader signals between the CPU side and the memory responder.
// dbg_state mirrors the loader FSM state so checkers can bind to it.
interface memory_responder_if;
    logic [7:0]   address;
    logic [7:0]   data_in;
    logic         write;
    logic [7:0]   data_out;
    logic [127:0] port_in;
    logic [127:0] port_out;
    logic         wr_fault;
    logic         ld_start;
    logic         ld_valid;
    logic [7:0]   ld_data;
    logic         ld_last;
    logic         ld_ready;
    logic         ld_done;
    logic         ld_ovf;
    logic         cpu_hold;
    logic [1:0]   dbg_state;

    modport master (
        output address, data_in, write, port_in,
        output ld_start, ld_valid, ld_data, ld_last,
        input  data_out, port_out, wr_fault,
        input  ld_ready, ld_done, ld_ovf, cpu_hold, dbg_state
    );

    modport slave (
        input  address, data_in, write, port_in,
        input  ld_start, ld_valid, ld_data, ld_last,
        output data_out, port_out, wr_fault,
        output ld_ready, ld_done, ld_ovf, cpu_hold, dbg_state
    );
endinterface

// File: rtl/memory_responder.sv
// Memory-side responder: ROM / RAM / output ports / synchronised input ports behind
// an 8-bit MAR, plus a byte-stream loader that fills ROM while the CPU is held.
module memory_responder #(
    parameter logic [7:0] RAM_BASE    = 8'h80,
    parameter logic [7:0] OUT_BASE    = 8'hE0,
    parameter logic [7:0] IN_BASE     = 8'hF0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    memory_responder_if.slave bus
);

    localparam int ROM_DEPTH = int'(RAM_BASE);
    localparam int RAM_DEPTH = int'(OUT_BASE) - int'(RAM_BASE);
    localparam int ROM_AW    = $clog2(ROM_DEPTH);
    localparam int RAM_AW    = $clog2(RAM_DEPTH);
    localparam logic [ROM_AW-1:0] ROM_LAST = ROM_AW'(ROM_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [ROM_AW-1:0]   ptr_q;
    logic                ld_ready_q;
    logic                ld_done_q;
    logic                ld_ovf_q;
    logic                cpu_hold_q;
    logic                wr_fault_q;
    logic                wr_fault_d;
    logic [127:0]        port_out_q;
    logic [127:0]        port_out_d;
    logic [127:0]        sync_q [SYNC_STAGES];
    logic [7:0]          rom_q [ROM_DEPTH];
    logic [7:0]          ram_q [RAM_DEPTH];
    logic [7:0]          data_out_d;

    logic                in_rom;
    logic                in_ram;
    logic                in_out;
    logic                in_in;
    logic [ROM_AW-1:0]   rom_idx;
    logic [RAM_AW-1:0]   ram_idx;
    logic [3:0]          out_idx;
    logic [3:0]          in_idx;
    logic                cpu_wr;
    logic                ld_xfer;

    assign in_rom  = (bus.address < RAM_BASE);
    assign in_ram  = (bus.address >= RAM_BASE) && (bus.address < OUT_BASE);
    assign in_out  = (bus.address >= OUT_BASE) && (bus.address < IN_BASE);
    assign in_in   = (bus.address >= IN_BASE);
    assign rom_idx = ROM_AW'(bus.address);
    assign ram_idx = RAM_AW'(bus.address - RAM_BASE);
    assign out_idx = 4'(bus.address - OUT_BASE);
    assign in_idx  = 4'(bus.address - IN_BASE);

    // CPU strobes are dropped while the loader owns the memory, and during Reset.
    assign cpu_wr  = bus.write && !cpu_hold_q && !Reset;

    // Loader handshake: a byte transfers on a posedge where ld_valid and ld_ready
    // are both 1; ld_ready is 1 only in LOAD, ld_valid may toggle freely.
    assign ld_xfer = (state_q == ST_LOAD) && bus.ld_valid;

    always_comb begin
        data_out_d = 8'h00;
        if (!cpu_hold_q) begin
            if (in_rom) begin
                data_out_d = rom_q[rom_idx];
            end else if (in_ram) begin
                data_out_d = ram_q[ram_idx];
            end else if (in_out) begin
                data_out_d = port_out_q[out_idx*8 +: 8];
            end else begin
                data_out_d = sync_q[SYNC_STAGES-1][in_idx*8 +: 8];
            end
        end
    end

    always_comb begin
        port_out_d = port_out_q;
        wr_fault_d = wr_fault_q;
        if (cpu_wr && in_out) begin
            port_out_d[out_idx*8 +: 8] = bus.data_in;
        end
        if (cpu_wr && (in_rom || in_in)) begin
            wr_fault_d = 1'b1;
        end
    end

    // Storage arrays carry no reset so a mid-load Reset keeps bytes already written.
    always_ff @(posedge Clk) begin
        if (ld_xfer) begin
            rom_q[ptr_q] <= bus.ld_data;
        end
        if (cpu_wr && in_ram) begin
            ram_q[ram_idx] <= bus.data_in;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
            ld_ovf_q   <= 1'b0;
            cpu_hold_q <= 1'b0;
            wr_fault_q <= 1'b0;
            port_out_q <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            wr_fault_q <= wr_fault_d;
            port_out_q <= port_out_d;
            sync_q[0]  <= bus.port_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end

            case (state_q)
                ST_IDLE: begin
                    ld_done_q <= 1'b0;
                    if (bus.ld_start) begin
                        state_q    <= ST_LOAD;
                        ptr_q      <= '0;
                        ld_ovf_q   <= 1'b0;
                        ld_ready_q <= 1'b1;
                        cpu_hold_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (bus.ld_valid) begin
                        ptr_q <= ptr_q + 1'b1;
                        // The last ROM slot closes the load even without ld_last.
                        if (bus.ld_last || (ptr_q == ROM_LAST)) begin
                            state_q    <= ST_DONE;
                            ld_ready_q <= 1'b0;
                            ld_done_q  <= 1'b1;
                            if (!bus.ld_last) begin
                                ld_ovf_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    ld_done_q  <= 1'b0;
                    cpu_hold_q <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    ld_ready_q <= 1'b0;
                    ld_done_q  <= 1'b0;
                    cpu_hold_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_out_d;
    assign bus.port_out  = port_out_q;
    assign bus.wr_fault  = wr_fault_q;
    assign bus.ld_ready  = ld_ready_q;
    assign bus.ld_done   = ld_done_q;
    assign bus.ld_ovf    = ld_ovf_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.dbg_state = state_q;

endmodule
